// File: rtl/insn_aligner_if.sv
// Handshake bundle between the instruction buffer, the aligner and decode.
// The master side feeds entries and consumes aligned instructions; the aligner is the slave.
interface insn_aligner_if;
  logic        entryValid;
  logic [53:0] entry;
  logic        entryReady;
  logic        flush;
  logic        outValid;
  logic        outReady;
  logic [31:0] outPc;
  logic [31:0] outInsn;
  logic        outIsCompressed;
  logic [37:0] outTrap;

  modport master (
    output entryValid, entry, flush, outReady,
    input  entryReady, outValid, outPc, outInsn, outIsCompressed, outTrap
  );

  modport slave (
    input  entryValid, entry, flush, outReady,
    output entryReady, outValid, outPc, outInsn, outIsCompressed, outTrap
  );
endinterface

// File: rtl/insn_aligner.sv
// Reassembles 16-bit instruction-buffer halfwords into compressed or 32-bit instructions,
// turning entry faults and interrupts into trap records for decode.
module insn_aligner (
  input  logic           clk,
  input  logic           rstN,
  insn_aligner_if.slave  bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HALF = 1'b1;

  logic [0:0]  state;
  logic [0:0]  nxt_state;
  logic [15:0] low_insn;
  logic [31:0] low_pc;

  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_insn;
  logic        out_comp;
  logic [37:0] out_trap;

  logic [31:0] e_pc;
  logic [15:0] e_insn;
  logic        e_fault;
  logic        e_intr;
  logic [3:0]  e_code;

  logic        can_load;
  logic        load;
  logic        emit;
  logic        latch_low;
  logic [31:0] nxt_pc;
  logic [31:0] nxt_insn;
  logic        nxt_comp;
  logic [37:0] nxt_trap;

  assign e_pc    = bus.entry[53:22];
  assign e_insn  = bus.entry[21:6];
  assign e_fault = bus.entry[5];
  assign e_intr  = bus.entry[4];
  assign e_code  = bus.entry[3:0];

  // Reset gating keeps the buffer from popping while the aligner is held in reset.
  assign can_load       = !out_valid || bus.outReady;
  assign bus.entryReady = rstN && can_load && !bus.flush;
  assign load           = bus.entryValid && bus.entryReady;

  assign bus.outValid        = out_valid;
  assign bus.outPc           = out_pc;
  assign bus.outInsn         = out_insn;
  assign bus.outIsCompressed = out_comp;
  assign bus.outTrap         = out_trap;

  always_comb begin
    emit      = 1'b0;
    latch_low = 1'b0;
    nxt_state = state;
    nxt_pc    = e_pc;
    nxt_insn  = 32'h0;
    nxt_comp  = 1'b0;
    nxt_trap  = 38'h0;
    if (state == IDLE) begin
      if (e_intr) begin
        emit     = 1'b1;
        nxt_trap = {1'b1, 1'b1, e_code, 32'h0};
      end else if (e_fault) begin
        emit     = 1'b1;
        nxt_trap = {1'b1, 1'b0, 4'h1, e_pc};
      end else if (e_insn[1:0] != 2'b11) begin
        emit     = 1'b1;
        nxt_insn = {16'h0, e_insn};
        nxt_comp = 1'b1;
      end else begin
        latch_low = 1'b1;
        nxt_state = HALF;
      end
    end else begin
      // The upper halfword always completes the pending instruction; a trap reports the low pc.
      emit      = 1'b1;
      nxt_state = IDLE;
      nxt_pc    = low_pc;
      if (e_intr) begin
        nxt_trap = {1'b1, 1'b1, e_code, 32'h0};
      end else if (e_fault) begin
        nxt_trap = {1'b1, 1'b0, 4'h1, e_pc};
      end else begin
        nxt_insn = {e_insn, low_insn};
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state     <= IDLE;
      low_insn  <= 16'h0;
      low_pc    <= 32'h0;
      out_valid <= 1'b0;
      out_pc    <= 32'h0;
      out_insn  <= 32'h0;
      out_comp  <= 1'b0;
      out_trap  <= 38'h0;
    end else if (bus.flush) begin
      out_valid <= 1'b0;
      state     <= IDLE;
    end else if (load) begin
      state     <= nxt_state;
      out_valid <= emit;
      if (emit) begin
        out_pc   <= nxt_pc;
        out_insn <= nxt_insn;
        out_comp <= nxt_comp;
        out_trap <= nxt_trap;
      end
      if (latch_low) begin
        low_insn <= e_insn;
        low_pc   <= e_pc;
      end
    end else if (out_valid && bus.outReady) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_insn_aligner.sv
// Randomized and directed checks of insn_aligner against a halfword-pairing reference model.
module tb_insn_aligner;

  logic clk = 1'b0;
  logic rstN = 1'b0;

  insn_aligner_if ifc();

  insn_aligner dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (ifc)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: one pending output record plus an optional held low halfword.
  logic        m_valid = 1'b0;
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_insn = 32'h0;
  logic        m_comp = 1'b0;
  logic [37:0] m_trap = 38'h0;
  logic        have_half = 1'b0;
  logic [31:0] half_pc = 32'h0;
  logic [15:0] half_insn = 16'h0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [53:0] mkEntry(input logic [31:0] pc, input logic [15:0] insn,
                                          input logic fault, input logic intr, input logic [3:0] code);
    return {pc, insn, fault, intr, code};
  endfunction

  task automatic modelAccept(input logic [53:0] e);
    logic [31:0] pc;
    logic [15:0] insn;
    logic        fault;
    logic        intr;
    logic [3:0]  code;
    {pc, insn, fault, intr, code} = e;
    m_valid = 1'b1;
    m_insn  = 32'h0;
    m_comp  = 1'b0;
    m_trap  = 38'h0;
    m_pc    = have_half ? half_pc : pc;
    if (intr)
      m_trap = {1'b1, 1'b1, code, 32'h0};
    else if (fault)
      m_trap = {1'b1, 1'b0, 4'h1, pc};
    else if (have_half)
      m_insn = {insn, half_insn};
    else if (insn[1:0] != 2'b11) begin
      m_insn = {16'h0, insn};
      m_comp = 1'b1;
    end else begin
      m_valid   = 1'b0;
      have_half = 1'b1;
      half_pc   = pc;
      half_insn = insn;
      return;
    end
    have_half = 1'b0;
  endtask

  task automatic applyStimulus(input logic ev, input logic [53:0] e, input logic fl, input logic ordy);
    logic exp_ready;
    @(negedge clk);
    ifc.entryValid = ev;
    ifc.entry      = e;
    ifc.flush      = fl;
    ifc.outReady   = ordy;
    #1;
    exp_ready = (!m_valid || ordy) && !fl;
    checkOutput("entryReady", 64'(ifc.entryReady), 64'(exp_ready));
    checkOutput("outValid", 64'(ifc.outValid), 64'(m_valid));
    if (m_valid) begin
      checkOutput("outPc", 64'(ifc.outPc), 64'(m_pc));
      checkOutput("outInsn", 64'(ifc.outInsn), 64'(m_insn));
      checkOutput("outIsCompressed", 64'(ifc.outIsCompressed), 64'(m_comp));
      checkOutput("outTrap", 64'(ifc.outTrap), 64'(m_trap));
    end
    if (fl) begin
      m_valid   = 1'b0;
      have_half = 1'b0;
    end else if (ev && exp_ready)
      modelAccept(e);
    else if (m_valid && ordy)
      m_valid = 1'b0;
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] insn;
    ifc.entryValid = 1'b1;
    ifc.entry      = mkEntry(32'h80000000, 16'h4501, 1'b0, 1'b0, 4'h0);
    ifc.flush      = 1'b0;
    ifc.outReady   = 1'b1;
    #3;
    checkOutput("rst_outValid", 64'(ifc.outValid), 64'h0);
    checkOutput("rst_outPc", 64'(ifc.outPc), 64'h0);
    checkOutput("rst_outInsn", 64'(ifc.outInsn), 64'h0);
    checkOutput("rst_outComp", 64'(ifc.outIsCompressed), 64'h0);
    checkOutput("rst_outTrap", 64'(ifc.outTrap), 64'h0);
    checkOutput("rst_entryReady", 64'(ifc.entryReady), 64'h0);
    @(negedge clk);
    ifc.entryValid = 1'b0;
    rstN = 1'b1;

    applyStimulus(1'b1, mkEntry(32'h80000000, 16'h4501, 1'b0, 1'b0, 4'h0), 1'b0, 1'b1);
    settle();
    checkOutput("c_valid", 64'(ifc.outValid), 64'h1);
    checkOutput("c_insn", 64'(ifc.outInsn), 64'h00004501);
    checkOutput("c_comp", 64'(ifc.outIsCompressed), 64'h1);
    checkOutput("c_pc", 64'(ifc.outPc), 64'h80000000);

    applyStimulus(1'b1, mkEntry(32'h80000002, 16'h0513, 1'b0, 1'b0, 4'h0), 1'b0, 1'b1);
    applyStimulus(1'b1, mkEntry(32'h80000004, 16'h0000, 1'b0, 1'b0, 4'h0), 1'b0, 1'b1);
    settle();
    checkOutput("s_insn", 64'(ifc.outInsn), 64'h00000513);
    checkOutput("s_pc", 64'(ifc.outPc), 64'h80000002);
    checkOutput("s_comp", 64'(ifc.outIsCompressed), 64'h0);

    applyStimulus(1'b1, mkEntry(32'h80000FFE, 16'h00B7, 1'b0, 1'b0, 4'h0), 1'b0, 1'b1);
    applyStimulus(1'b1, mkEntry(32'h80001000, 16'h0000, 1'b1, 1'b0, 4'h0), 1'b0, 1'b1);
    settle();
    checkOutput("uf_trap", 64'(ifc.outTrap), 64'({1'b1, 1'b0, 4'h1, 32'h80001000}));
    checkOutput("uf_pc", 64'(ifc.outPc), 64'h80000FFE);

    applyStimulus(1'b1, mkEntry(32'h80002000, 16'h1234, 1'b1, 1'b1, 4'h7), 1'b0, 1'b1);
    settle();
    checkOutput("if_trap", 64'(ifc.outTrap), 64'({1'b1, 1'b1, 4'h7, 32'h0}));

    // Stall with a pending output, then stream compressed entries back to back.
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, mkEntry(32'h80003000, 16'h4501, 1'b0, 1'b0, 4'h0), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, mkEntry(32'h80003000 + 32'(2 * i), 16'h4500 + 16'(4 * i + 1), 1'b0, 1'b0, 4'h0), 1'b0, 1'b1);
    applyStimulus(1'b0, 54'h0, 1'b0, 1'b1);

    applyStimulus(1'b1, mkEntry(32'h80004000, 16'h0513, 1'b0, 1'b0, 4'h0), 1'b0, 1'b1);
    applyStimulus(1'b1, mkEntry(32'h80004002, 16'h0000, 1'b0, 1'b0, 4'h0), 1'b1, 1'b1);
    applyStimulus(1'b1, mkEntry(32'h80005000, 16'h4501, 1'b0, 1'b0, 4'h0), 1'b0, 1'b1);
    settle();
    checkOutput("fl_comp", 64'(ifc.outIsCompressed), 64'h1);
    checkOutput("fl_insn", 64'(ifc.outInsn), 64'h00004501);

    // Reset while a low halfword is held must drop it.
    applyStimulus(1'b1, mkEntry(32'h80006000, 16'h0513, 1'b0, 1'b0, 4'h0), 1'b0, 1'b1);
    applyStimulus(1'b1, mkEntry(32'h80006100, 16'h0093, 1'b0, 1'b0, 4'h0), 1'b0, 1'b1);
    #2;
    ifc.entryValid = 1'b0;
    rstN = 1'b0;
    #1;
    checkOutput("mr_outValid", 64'(ifc.outValid), 64'h0);
    checkOutput("mr_entryReady", 64'(ifc.entryReady), 64'h0);
    m_valid   = 1'b0;
    have_half = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    applyStimulus(1'b1, mkEntry(32'h80007000, 16'h4501, 1'b0, 1'b0, 4'h0), 1'b0, 1'b1);
    settle();
    checkOutput("mr_comp", 64'(ifc.outIsCompressed), 64'h1);

    for (int i = 0; i < 2000; i++) begin
      insn = 16'($urandom);
      if ($urandom_range(0, 1) == 1) insn[1:0] = 2'b11;
      applyStimulus($urandom_range(0, 3) != 0,
                    mkEntry($urandom, insn, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                            4'($urandom)),
                    $urandom_range(0, 12) == 0,
                    $urandom_range(0, 9) < 7);
    end
    applyStimulus(1'b0, 54'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 54'h0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/insn_aligner.md
INSN_ALIGNER -- requirements
Module: insn_aligner

Interface
REQ-001 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port: rstN  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port: entryValid  input  1  insn buffer head entry valid.
REQ-004 SHALL have port: entry  input  54  InsnBufferEntry {pc[31:0], insn[15:0], fault, interruptValid, interruptCode[3:0]}.
REQ-005 SHALL have port: entryReady  output  1  pop strobe; entry consumed when entryValid && entryReady.
REQ-006 SHALL have port: flush  input  1  pipeline flush (any FlushReason).
REQ-007 SHALL have port: outValid  output  1  aligned instruction valid to decode.
REQ-008 SHALL have port: outReady  input  1  decode accepts; transfer when outValid && outReady.
REQ-009 SHALL have port: outPc  output  32  pc of instruction's first halfword.
REQ-010 SHALL have port: outInsn  output  32  insn_t; compressed insns zero-extended.
REQ-011 SHALL have port: outIsCompressed  output  1  16-bit instruction.
REQ-012 SHALL have port: outTrap  output  38  TrapInfo {valid, cause{isInterrupt, code[3:0]}, value[31:0]}.

Function
REQ-013 SHALL hold state IDLE (no partial insn) or HALF (lower halfword and its pc held in lowInsn/lowPc).
REQ-014 SHALL register all out* signals; output latency from consumed entry to outValid is 1 cycle.
REQ-015 SHALL define canLoad = !outValid || outReady; entryReady = canLoad && !flush, combinational.
REQ-016 IDLE, entry.interruptValid: emit trap, outPc=entry.pc, outInsn=0, cause={1,interruptCode}, value=0; stay IDLE.
REQ-017 IDLE, entry.fault (no interrupt): emit trap, cause={0,4'h1}, value=entry.pc, outPc=entry.pc; stay IDLE.
REQ-018 IDLE, insn[1:0]!=2'b11: emit outInsn={16'h0,insn}, outIsCompressed=1, outTrap.valid=0; stay IDLE.
REQ-019 IDLE, insn[1:0]==2'b11: latch lowInsn/lowPc, go HALF, no emission.
REQ-020 HALF, upper.interruptValid: emit interrupt trap with outPc=lowPc, value=0; go IDLE.
REQ-021 HALF, upper.fault (no interrupt): emit trap cause={0,4'h1}, value=upper.pc, outPc=lowPc; go IDLE.
REQ-022 HALF, otherwise: emit outInsn={upper.insn,lowInsn}, outPc=lowPc, outIsCompressed=0; go IDLE.
REQ-023 Interrupt SHALL take priority over fault; trap emissions SHALL set outIsCompressed=0.
REQ-024 Output SHALL hold stable while outValid && !outReady; no entry consumed in that cycle.
REQ-025 outValid SHALL clear on transfer when no new entry emits in the same cycle; back-to-back emission SHALL sustain one insn per cycle.
REQ-026 flush SHALL have highest priority: next cycle outValid=0, state IDLE, held half discarded; no entry consumed during flush.
REQ-027 SHALL accept pc arithmetic as-is from entries; no contiguity check on upper halfword.

Reset
REQ-028 On rstN low, asynchronously: state IDLE, outValid=0, outPc=0, outInsn=0, outIsCompressed=0, outTrap=0, lowInsn=0, lowPc=0.
REQ-029 Reset asserted mid-HALF SHALL discard held halfword; first post-reset entry treated as IDLE.
REQ-030 entryReady SHALL be 0 while rstN low.

Verification
REQ-031 Compressed: entry{pc=80000000,insn=4501} outReady=1 -> next cycle outValid=1, outInsn=00004501, outIsCompressed=1, outPc=80000000.
REQ-032 Split 32-bit: entries {80000002,0513},{80000004,0000} consecutive -> one emission outInsn=00000513, outPc=80000002, outIsCompressed=0.
REQ-033 Upper fault: {80000FFE,00B7} then {80001000,fault=1} -> outTrap={1,{0,1},80001000}, outPc=80000FFE.
REQ-034 Stall: outReady=0 for 3 cycles with entryValid=1 -> entryReady=0, out* unchanged, then one transfer per cycle after outReady=1.
REQ-035 Flush in HALF with outValid=1 -> next cycle outValid=0, state IDLE; following {pc,4501} emits compressed, not merged.
REQ-036 Interrupt+fault same entry, code=7 -> outTrap.cause={1,7}, value=0.
